// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches from word-addressed instruction
// memory and registers the word into IF/ID, handling stall, redirect, flush and fetch faults.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        if_id_exc
);

  localparam logic [0:0]  RUN       = 1'b0;
  localparam logic [0:0]  FAULT     = 1'b1;
  localparam logic [31:0] WIN_BYTES = 32'(4 * IM_WORDS);

  logic [0:0]  state;
  logic        pend;
  logic [31:0] pend_pc;
  logic [31:0] offset;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        fault;

  // Window test is done on the wrapped offset, so one unsigned compare covers both ends.
  always_comb begin
    offset   = pc - RESET_PC;
    pc_plus4 = pc + 32'd4;
    fault    = (pc[1:0] != 2'b00) || (offset >= WIN_BYTES);
    next_pc  = pc_plus4;
    if (redirect)  next_pc = redirect_pc;
    else if (pend) next_pc = pend_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= RUN;
      pend        <= 1'b0;
      pend_pc     <= '0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      if_id_exc   <= 1'b0;
    end else if (flush) begin
      pc          <= flush_pc;
      state       <= RUN;
      pend        <= 1'b0;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
      if_id_exc   <= 1'b0;
    end else if (stall) begin
      if (redirect) begin
        pend    <= 1'b1;
        pend_pc <= redirect_pc;
      end
    end else if (state == RUN) begin
      if_id_pc    <= pc;
      if_id_pc4   <= pc_plus4;
      if_id_valid <= 1'b1;
      if (fault) begin
        if_id_instr <= '0;
        if_id_exc   <= 1'b1;
        state       <= FAULT;
      end else begin
        if_id_instr <= instr;
        if_id_exc   <= 1'b0;
        pc          <= next_pc;
        pend        <= 1'b0;
      end
    end else begin
      // FAULT: emit bubbles and ignore redirects until a flush arrives.
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
      if_id_exc   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomised self-checking bench for if_stage against a behavioural fetch model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int unsigned IM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;
  logic [31:0] if_id_instr, if_id_pc, if_id_pc4;
  logic        if_id_valid, if_id_exc;

  logic [31:0] mem [IM_WORDS];

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [31:0] m_pc, m_tgt, m_instr, m_ipc, m_ipc4;
  bit          m_faulted, m_pend, m_valid, m_exc;

  if_stage #(.RESET_PC(RESET_PC), .IM_WORDS(IM_WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .flush(flush), .flush_pc(flush_pc),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .if_id_exc(if_id_exc)
  );

  always #5 clk = ~clk;

  always_comb instr = mem[pc[11:2]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  function automatic bit bad_addr(input logic [31:0] a);
    longint lo, hi, v;
    lo = longint'(RESET_PC);
    hi = lo + 4 * longint'(IM_WORDS);
    v  = longint'(a);
    return (a % 4 != 0) || (v < lo) || (v >= hi);
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_faulted = 0; m_pend = 0; m_tgt = '0;
    m_instr = '0; m_ipc = '0; m_ipc4 = '0; m_valid = 0; m_exc = 0;
  endtask

  task automatic model_bubble();
    m_instr = '0; m_valid = 0; m_exc = 0;
  endtask

  task automatic model_step();
    if (flush) begin
      m_pc = flush_pc; model_bubble(); m_pend = 0; m_faulted = 0;
    end else if (stall) begin
      if (redirect) begin m_pend = 1; m_tgt = redirect_pc; end
    end else if (!m_faulted) begin
      m_ipc = m_pc; m_ipc4 = m_pc + 4; m_valid = 1;
      if (bad_addr(m_pc)) begin
        m_instr = '0; m_exc = 1; m_faulted = 1;
      end else begin
        m_instr = mem[(m_pc - RESET_PC) / 4]; m_exc = 0;
        if (redirect)    m_pc = redirect_pc;
        else if (m_pend) m_pc = m_tgt;
        else             m_pc = m_pc + 4;
        m_pend = 0;
      end
    end else begin
      model_bubble();
    end
  endtask

  task automatic check_all();
    check("pc",          pc,                  m_pc);
    check("if_id_instr", if_id_instr,         m_instr);
    check("if_id_pc",    if_id_pc,            m_ipc);
    check("if_id_pc4",   if_id_pc4,           m_ipc4);
    check("if_id_valid", {31'd0, if_id_valid}, {31'd0, m_valid});
    check("if_id_exc",   {31'd0, if_id_exc},   {31'd0, m_exc});
  endtask

  task automatic step(input bit st, input bit rd, input logic [31:0] rpc,
                      input bit fl, input logic [31:0] fpc);
    stall = st; redirect = rd; redirect_pc = rpc; flush = fl; flush_pc = fpc;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0);
  endtask

  task automatic check_reset_values();
    check("rst_pc",    pc,          RESET_PC);
    check("rst_instr", if_id_instr, 32'd0);
    check("rst_ipc",   if_id_pc,    32'd0);
    check("rst_ipc4",  if_id_pc4,   32'd0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_exc",   {31'd0, if_id_exc},   32'd0);
  endtask

  logic [31:0] tgt;

  initial begin
    for (int unsigned i = 0; i < IM_WORDS; i++) mem[i] = $urandom;
    for (int unsigned i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;

    // free-running fetch of words 1..4
    for (int i = 0; i < 4; i++) begin
      idle();
      check("seq_pc",    if_id_pc,    RESET_PC + 32'(4 * i));
      check("seq_instr", if_id_instr, 32'(i + 1));
    end

    // restart, then redirect with delay slot at pc=0x3008
    step(0, 0, '0, 1, 32'h3000);
    check("flush_bubble", {31'd0, if_id_valid}, 32'd0);
    idle(); idle();
    step(0, 1, 32'h3100, 0, '0);
    check("dslot_pc", if_id_pc, 32'h3008);
    check("redir_pc", pc, 32'h3100);
    idle();
    check("redir_tgt", if_id_pc, 32'h3100);

    // stall 3 cycles with redirect in the first only
    step(1, 1, 32'h3200, 0, '0);
    step(1, 0, '0, 0, '0);
    step(1, 0, '0, 0, '0);
    idle();
    check("pend_pc", pc, 32'h3200);
    idle();

    // misaligned redirect -> fault; later redirects ignored
    step(0, 1, 32'h3002, 0, '0);
    idle();
    check("mis_exc", {31'd0, if_id_exc}, 32'd1);
    step(0, 1, 32'h3100, 0, '0);
    check("fault_hold", pc, 32'h3002);

    // flush during stall while faulted, to out-of-window address
    step(1, 0, '0, 1, 32'h4180);
    check("fl_pc", pc, 32'h4180);
    idle();
    check("oow_exc", {31'd0, if_id_exc}, 32'd1);
    idle(); idle();
    check("oow_hold", pc, 32'h4180);
    step(0, 0, '0, 1, 32'h3000);
    idle(); idle();

    // async reset while pending is set
    step(1, 1, 32'h3300, 0, '0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    check("rst_restart", if_id_pc, RESET_PC);
    idle();
    check("rst_nopend", if_id_pc, RESET_PC + 32'd4);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit st, rd, fl;
      logic [31:0] fpc;
      st  = ($urandom_range(99) < 25);
      rd  = ($urandom_range(99) < 20);
      fl  = ($urandom_range(99) < 5);
      tgt = RESET_PC + 32'($urandom_range(IM_WORDS - 1) * 4);
      if ($urandom_range(9) == 0) tgt = $urandom;
      if ($urandom_range(19) == 0) tgt = RESET_PC + 32'(4 * IM_WORDS) - 32'd4;
      fpc = RESET_PC + 32'($urandom_range(IM_WORDS - 1) * 4);
      step(st, rd, tgt, fl, fpc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
